ocp_dual_master_arbiter: RTL and testbench

- Shares one downstream OCP slave between two upstream OCP masters (u0, u1).
- Arbitrates commands round-robin and holds the grant through the write-data phase of a granted write burst.
- Encodes the granted master index into the tag MSB and routes responses back by the s_tagid MSB.
- Sits between the master-side bus ports and the ocp_if slave link.

---
 rtl/ocp_dual_master_arbiter.sv | 267 ++++++++++++++++++++++++++
 tb/tb_ocp_dual_master_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ocp_dual_master_arbiter.sv
// ocp_dual_master_arbiter
//
// Shares one downstream OCP slave between two upstream OCP masters (u0, u1).
// Commands are arbitrated round-robin; a granted write keeps the grant until
// its last write-data beat has been accepted. The granted master index is
// carried in the downstream tag MSB, and responses are steered back to the
// master named by the MSB of s_tagid.
//
// Ports
//   clk, rst                      clock and synchronous active-high reset
//   uN_m_cmd .. uN_m_tagid        upstream command request (N = 0, 1)
//   uN_s_cmd_accept               upstream command accept
//   uN_m_data .. uN_m_data_last   upstream write data
//   uN_s_data_accept              upstream write data accept
//   uN_s_resp .. uN_s_tagid       upstream response
//   uN_m_resp_accept              upstream response accept
//   m_*                           downstream master-side outputs
//   s_*                           downstream slave-side inputs

module ocp_dual_master_arbiter #(
  parameter int unsigned TAGI_WIDTH = 5,
  parameter int unsigned INFO_WIDTH = 4,
  parameter int unsigned BLEN_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,

  // Upstream master 0
  input  logic [2:0]                u0_m_cmd,
  input  logic [ADDR_WIDTH-1:0]     u0_m_addr,
  input  logic [BLEN_WIDTH-1:0]     u0_m_burst_length,
  input  logic [2:0]                u0_m_burst_seq,
  input  logic [DATA_WIDTH/8-1:0]   u0_m_byteen,
  input  logic [INFO_WIDTH-1:0]     u0_m_req_info,
  input  logic [TAGI_WIDTH-2:0]     u0_m_tagid,
  output logic                      u0_s_cmd_accept,
  input  logic [DATA_WIDTH-1:0]     u0_m_data,
  input  logic [DATA_WIDTH/8-1:0]   u0_m_data_byteen,
  input  logic [TAGI_WIDTH-2:0]     u0_m_data_tagid,
  input  logic                      u0_m_data_valid,
  input  logic                      u0_m_data_last,
  output logic                      u0_s_data_accept,
  output logic [1:0]                u0_s_resp,
  output logic                      u0_s_resp_last,
  output logic [DATA_WIDTH-1:0]     u0_s_data,
  output logic [TAGI_WIDTH-2:0]     u0_s_tagid,
  input  logic                      u0_m_resp_accept,

  // Upstream master 1
  input  logic [2:0]                u1_m_cmd,
  input  logic [ADDR_WIDTH-1:0]     u1_m_addr,
  input  logic [BLEN_WIDTH-1:0]     u1_m_burst_length,
  input  logic [2:0]                u1_m_burst_seq,
  input  logic [DATA_WIDTH/8-1:0]   u1_m_byteen,
  input  logic [INFO_WIDTH-1:0]     u1_m_req_info,
  input  logic [TAGI_WIDTH-2:0]     u1_m_tagid,
  output logic                      u1_s_cmd_accept,
  input  logic [DATA_WIDTH-1:0]     u1_m_data,
  input  logic [DATA_WIDTH/8-1:0]   u1_m_data_byteen,
  input  logic [TAGI_WIDTH-2:0]     u1_m_data_tagid,
  input  logic                      u1_m_data_valid,
  input  logic                      u1_m_data_last,
  output logic                      u1_s_data_accept,
  output logic [1:0]                u1_s_resp,
  output logic                      u1_s_resp_last,
  output logic [DATA_WIDTH-1:0]     u1_s_data,
  output logic [TAGI_WIDTH-2:0]     u1_s_tagid,
  input  logic                      u1_m_resp_accept,

  // Downstream master side
  output logic [2:0]                m_cmd,
  output logic [ADDR_WIDTH-1:0]     m_addr,
  output logic [BLEN_WIDTH-1:0]     m_burst_length,
  output logic [2:0]                m_burst_seq,
  output logic [DATA_WIDTH/8-1:0]   m_byteen,
  output logic [INFO_WIDTH-1:0]     m_req_info,
  output logic [TAGI_WIDTH-1:0]     m_tagid,
  output logic [DATA_WIDTH-1:0]     m_data,
  output logic [DATA_WIDTH/8-1:0]   m_data_byteen,
  output logic [TAGI_WIDTH-1:0]     m_data_tagid,
  output logic                      m_data_valid,
  output logic                      m_data_last,
  output logic                      m_resp_accept,

  // Downstream slave side
  input  logic                      s_cmd_accept,
  input  logic                      s_data_accept,
  input  logic [1:0]                s_resp,
  input  logic                      s_resp_last,
  input  logic [DATA_WIDTH-1:0]     s_data,
  input  logic [TAGI_WIDTH-1:0]     s_tagid
);

  localparam logic [2:0] CmdIdle = 3'b000;
  localparam logic [2:0] CmdWr   = 3'b001;
  localparam logic [1:0] RespNull = 2'b00;

  typedef enum logic [1:0] {
    StIdle,
    StCmd,
    StWdata
  } state_e;

  state_e state_q, state_d;
  logic   grant_q, grant_d;  // index of the master currently owning the link
  logic   rr_q, rr_d;        // 0: u0 wins a tie, 1: u1 wins a tie

  logic req0, req1;

  // Granted master's request, selected once and shared by both phases
  logic [2:0]              g_cmd;
  logic [ADDR_WIDTH-1:0]   g_addr;
  logic [BLEN_WIDTH-1:0]   g_burst_length;
  logic [2:0]              g_burst_seq;
  logic [DATA_WIDTH/8-1:0] g_byteen;
  logic [INFO_WIDTH-1:0]   g_req_info;
  logic [TAGI_WIDTH-2:0]   g_tagid;
  logic [DATA_WIDTH-1:0]   g_data;
  logic [DATA_WIDTH/8-1:0] g_data_byteen;
  logic [TAGI_WIDTH-2:0]   g_data_tagid;
  logic                    g_data_valid;
  logic                    g_data_last;

  logic resp_sel;

  assign req0 = (u0_m_cmd != CmdIdle);
  assign req1 = (u1_m_cmd != CmdIdle);

  always_comb begin
    if (grant_q) begin
      g_cmd          = u1_m_cmd;
      g_addr         = u1_m_addr;
      g_burst_length = u1_m_burst_length;
      g_burst_seq    = u1_m_burst_seq;
      g_byteen       = u1_m_byteen;
      g_req_info     = u1_m_req_info;
      g_tagid        = u1_m_tagid;
      g_data         = u1_m_data;
      g_data_byteen  = u1_m_data_byteen;
      g_data_tagid   = u1_m_data_tagid;
      g_data_valid   = u1_m_data_valid;
      g_data_last    = u1_m_data_last;
    end else begin
      g_cmd          = u0_m_cmd;
      g_addr         = u0_m_addr;
      g_burst_length = u0_m_burst_length;
      g_burst_seq    = u0_m_burst_seq;
      g_byteen       = u0_m_byteen;
      g_req_info     = u0_m_req_info;
      g_tagid        = u0_m_tagid;
      g_data         = u0_m_data;
      g_data_byteen  = u0_m_data_byteen;
      g_data_tagid   = u0_m_data_tagid;
      g_data_valid   = u0_m_data_valid;
      g_data_last    = u0_m_data_last;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      grant_q <= 1'b0;
      rr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    unique case (state_q)
      StIdle: begin
        if (req0 && req1) begin
          grant_d = rr_q;
          state_d = StCmd;
        end else if (req0) begin
          grant_d = 1'b0;
          state_d = StCmd;
        end else if (req1) begin
          grant_d = 1'b1;
          state_d = StCmd;
        end
      end
      StCmd: begin
        // A withdrawn command keeps the grant parked here until it returns
        if (s_cmd_accept && (g_cmd != CmdIdle)) begin
          rr_d    = ~grant_q;
          state_d = (g_cmd == CmdWr) ? StWdata : StIdle;
        end
      end
      StWdata: begin
        if (g_data_valid && s_data_accept && g_data_last) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Request-path outputs: everything idles to zero unless the phase forwards it
  always_comb begin
    m_cmd            = CmdIdle;
    m_addr           = '0;
    m_burst_length   = '0;
    m_burst_seq      = '0;
    m_byteen         = '0;
    m_req_info       = '0;
    m_tagid          = '0;
    m_data           = '0;
    m_data_byteen    = '0;
    m_data_tagid     = '0;
    m_data_valid     = 1'b0;
    m_data_last      = 1'b0;
    u0_s_cmd_accept  = 1'b0;
    u1_s_cmd_accept  = 1'b0;
    u0_s_data_accept = 1'b0;
    u1_s_data_accept = 1'b0;
    unique case (state_q)
      StCmd: begin
        m_cmd           = g_cmd;
        m_addr          = g_addr;
        m_burst_length  = g_burst_length;
        m_burst_seq     = g_burst_seq;
        m_byteen        = g_byteen;
        m_req_info      = g_req_info;
        m_tagid         = {grant_q, g_tagid};
        u0_s_cmd_accept = s_cmd_accept & ~grant_q;
        u1_s_cmd_accept = s_cmd_accept & grant_q;
      end
      StWdata: begin
        m_data           = g_data;
        m_data_byteen    = g_data_byteen;
        m_data_tagid     = {grant_q, g_data_tagid};
        m_data_valid     = g_data_valid;
        m_data_last      = g_data_last;
        u0_s_data_accept = s_data_accept & ~grant_q;
        u1_s_data_accept = s_data_accept & grant_q;
      end
      default: ;
    endcase
  end

  // Response path is purely combinational and ignores arbitration state
  assign resp_sel = s_tagid[TAGI_WIDTH-1];

  assign u0_s_resp      = resp_sel ? RespNull : s_resp;
  assign u0_s_resp_last = resp_sel ? 1'b0 : s_resp_last;
  assign u0_s_data      = resp_sel ? '0 : s_data;
  assign u0_s_tagid     = resp_sel ? '0 : s_tagid[TAGI_WIDTH-2:0];

  assign u1_s_resp      = resp_sel ? s_resp : RespNull;
  assign u1_s_resp_last = resp_sel ? s_resp_last : 1'b0;
  assign u1_s_data      = resp_sel ? s_data : '0;
  assign u1_s_tagid     = resp_sel ? s_tagid[TAGI_WIDTH-2:0] : '0;

  assign m_resp_accept = (s_resp != RespNull) &&
                         (resp_sel ? u1_m_resp_accept : u0_m_resp_accept);

endmodule

// File: tb/tb_ocp_dual_master_arbiter.sv
// Self-checking bench for ocp_dual_master_arbiter: directed scenarios followed
// by randomized traffic, all compared every cycle against a transaction-level
// reference model of the arbitration rules.

module tb_ocp_dual_master_arbiter;

  localparam logic [2:0] RD = 3'b010;
  localparam logic [2:0] WR = 3'b001;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Upstream stimulus
  logic [2:0]  cmd   [2];
  logic [4:0]  addr  [2];
  logic [3:0]  blen  [2];
  logic [2:0]  bseq  [2];
  logic [3:0]  ben   [2];
  logic [3:0]  info  [2];
  logic [3:0]  tag   [2];
  logic [31:0] wdata [2];
  logic [3:0]  dben  [2];
  logic [3:0]  dtag  [2];
  logic        dv    [2];
  logic        dlast [2];
  logic        racc  [2];

  // Upstream observations
  logic        u_cacc  [2];
  logic        u_dacc  [2];
  logic [1:0]  u_resp  [2];
  logic        u_rlast [2];
  logic [31:0] u_rdata [2];
  logic [3:0]  u_rtag  [2];

  // Downstream
  logic [2:0]  m_cmd;
  logic [4:0]  m_addr;
  logic [3:0]  m_burst_length;
  logic [2:0]  m_burst_seq;
  logic [3:0]  m_byteen;
  logic [3:0]  m_req_info;
  logic [4:0]  m_tagid;
  logic [31:0] m_data;
  logic [3:0]  m_data_byteen;
  logic [4:0]  m_data_tagid;
  logic        m_data_valid, m_data_last, m_resp_accept;
  logic        s_cmd_accept, s_data_accept, s_resp_last;
  logic [1:0]  s_resp;
  logic [31:0] s_data;
  logic [4:0]  s_tagid;

  ocp_dual_master_arbiter dut (
    .clk(clk), .rst(rst),
    .u0_m_cmd(cmd[0]), .u0_m_addr(addr[0]), .u0_m_burst_length(blen[0]),
    .u0_m_burst_seq(bseq[0]), .u0_m_byteen(ben[0]), .u0_m_req_info(info[0]),
    .u0_m_tagid(tag[0]), .u0_s_cmd_accept(u_cacc[0]), .u0_m_data(wdata[0]),
    .u0_m_data_byteen(dben[0]), .u0_m_data_tagid(dtag[0]), .u0_m_data_valid(dv[0]),
    .u0_m_data_last(dlast[0]), .u0_s_data_accept(u_dacc[0]), .u0_s_resp(u_resp[0]),
    .u0_s_resp_last(u_rlast[0]), .u0_s_data(u_rdata[0]), .u0_s_tagid(u_rtag[0]),
    .u0_m_resp_accept(racc[0]),
    .u1_m_cmd(cmd[1]), .u1_m_addr(addr[1]), .u1_m_burst_length(blen[1]),
    .u1_m_burst_seq(bseq[1]), .u1_m_byteen(ben[1]), .u1_m_req_info(info[1]),
    .u1_m_tagid(tag[1]), .u1_s_cmd_accept(u_cacc[1]), .u1_m_data(wdata[1]),
    .u1_m_data_byteen(dben[1]), .u1_m_data_tagid(dtag[1]), .u1_m_data_valid(dv[1]),
    .u1_m_data_last(dlast[1]), .u1_s_data_accept(u_dacc[1]), .u1_s_resp(u_resp[1]),
    .u1_s_resp_last(u_rlast[1]), .u1_s_data(u_rdata[1]), .u1_s_tagid(u_rtag[1]),
    .u1_m_resp_accept(racc[1]),
    .m_cmd(m_cmd), .m_addr(m_addr), .m_burst_length(m_burst_length),
    .m_burst_seq(m_burst_seq), .m_byteen(m_byteen), .m_req_info(m_req_info),
    .m_tagid(m_tagid), .m_data(m_data), .m_data_byteen(m_data_byteen),
    .m_data_tagid(m_data_tagid), .m_data_valid(m_data_valid), .m_data_last(m_data_last),
    .m_resp_accept(m_resp_accept),
    .s_cmd_accept(s_cmd_accept), .s_data_accept(s_data_accept), .s_resp(s_resp),
    .s_resp_last(s_resp_last), .s_data(s_data), .s_tagid(s_tagid)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model: who owns the link and whether it is in its write phase
  bit   busy, in_wr;
  logic owner, favour;

  // Master BFM state
  bit   rand_mode;
  int   wr_left [2];
  logic got_cacc [2], got_dacc [2];

  function automatic logic [63:0] cmd_bus_got();
    return 64'({m_cmd, m_addr, m_burst_length, m_burst_seq, m_byteen, m_req_info, m_tagid});
  endfunction

  function automatic logic [63:0] data_bus_got();
    return 64'({m_data_valid, m_data_last, m_data_byteen, m_data_tagid, m_data});
  endfunction

  task automatic sample();
    logic [63:0] e;
    logic        sel;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      got_cacc[i] = u_cacc[i];
      got_dacc[i] = u_dacc[i];
    end
    e = '0;
    if (busy && !in_wr)
      e = 64'({cmd[owner], addr[owner], blen[owner], bseq[owner], ben[owner], info[owner],
               owner, tag[owner]});
    check_val("cmd_bus", cmd_bus_got(), e);
    e = '0;
    if (busy && in_wr)
      e = 64'({dv[owner], dlast[owner], dben[owner], owner, dtag[owner], wdata[owner]});
    check_val("data_bus", data_bus_got(), e);
    e = 64'({busy && !in_wr && owner && s_cmd_accept, busy && !in_wr && !owner && s_cmd_accept,
             busy && in_wr && owner && s_data_accept, busy && in_wr && !owner && s_data_accept});
    check_val("accepts", 64'({u_cacc[1], u_cacc[0], u_dacc[1], u_dacc[0]}), e);
    sel = s_tagid[4];
    e = 64'({s_resp, s_resp_last, s_tagid[3:0], s_data});
    check_val("u0_resp", 64'({u_resp[0], u_rlast[0], u_rtag[0], u_rdata[0]}), sel ? '0 : e);
    check_val("u1_resp", 64'({u_resp[1], u_rlast[1], u_rtag[1], u_rdata[1]}), sel ? e : '0);
    check_val("m_resp_accept", 64'(m_resp_accept), 64'((s_resp != 2'b00) && racc[sel]));
  endtask

  task automatic model_update();
    if (rst) begin
      busy = 0; in_wr = 0; owner = 1'b0; favour = 1'b0;
    end else if (!busy) begin
      if (cmd[0] != 0 || cmd[1] != 0) begin
        owner = (cmd[0] != 0 && cmd[1] != 0) ? favour : (cmd[0] != 0 ? 1'b0 : 1'b1);
        busy  = 1;
      end
    end else if (!in_wr) begin
      if (s_cmd_accept && cmd[owner] != 0) begin
        favour = ~owner;
        if (cmd[owner] == WR) in_wr = 1;
        else busy = 0;
      end
    end else if (dv[owner] && s_data_accept && dlast[owner]) begin
      busy = 0; in_wr = 0;
    end
  endtask

  task automatic load(input int i, input logic [2:0] c, input logic [4:0] a,
                      input logic [3:0] t, input logic [3:0] bl);
    cmd[i]  = c;
    addr[i] = a;
    tag[i]  = t;
    blen[i] = bl;
    bseq[i] = 3'($urandom);
    ben[i]  = 4'($urandom);
    info[i] = 4'($urandom);
  endtask

  task automatic bfm_update();
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        cmd[i] = 0; wr_left[i] = 0;
      end else begin
        if (dv[i] && got_dacc[i] && wr_left[i] > 0) wr_left[i]--;
        if (cmd[i] != 0 && got_cacc[i]) begin
          if (cmd[i] == WR) begin
            wr_left[i] = int'(blen[i]);
            dtag[i]    = tag[i];
          end
          cmd[i] = 0;
        end
        if (rand_mode && cmd[i] == 0 && wr_left[i] == 0 && $urandom_range(2) == 0)
          load(i, ($urandom_range(1) == 0) ? RD : WR, 5'($urandom), 4'($urandom),
               4'($urandom_range(4, 1)));
      end
      dv[i]    = (wr_left[i] > 0) && (!rand_mode || $urandom_range(3) != 0);
      dlast[i] = (wr_left[i] == 1);
      wdata[i] = $urandom;
      dben[i]  = 4'($urandom);
    end
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    #1;
    bfm_update();
    if (rand_mode) begin
      s_cmd_accept  = 1'($urandom);
      s_data_accept = ($urandom_range(3) != 0);
      s_resp        = {1'b0, 1'($urandom)};
      s_resp_last   = 1'($urandom);
      s_tagid       = 5'($urandom);
      s_data        = $urandom;
      racc[0]       = 1'($urandom);
      racc[1]       = 1'($urandom);
      rst           = ($urandom_range(399) == 0);
    end
  endtask

  task automatic cyc();
    sample();
    advance();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  task automatic quiet_slave();
    s_resp = 0; s_resp_last = 0; s_tagid = 0; s_data = 0; racc[0] = 0; racc[1] = 0;
  endtask

  logic [63:0] all_out;
  int   first, beats, last_beat, nacc, g0, g1;
  logic msb_q [$];

  initial begin
    for (int i = 0; i < 2; i++) begin
      cmd[i] = 0; addr[i] = 0; blen[i] = 0; bseq[i] = 0; ben[i] = 0; info[i] = 0;
      tag[i] = 0; wdata[i] = 0; dben[i] = 0; dtag[i] = 0; dv[i] = 0; dlast[i] = 0;
      racc[i] = 0; wr_left[i] = 0; got_cacc[i] = 0; got_dacc[i] = 0;
    end
    rand_mode = 0;
    s_cmd_accept = 0; s_data_accept = 0;
    quiet_slave();
    rst = 1'b1;
    @(posedge clk);
    model_update();
    #1;
    bfm_update();

    // Reset state
    sample();
    check_val("reset_cmd_bus", cmd_bus_got(), 64'h0);
    check_val("reset_data_bus", data_bus_got(), 64'h0);
    advance();
    rst = 1'b0;

    // Single RD from u0: one arbitration cycle, then forwarded with tag {0,3}
    s_cmd_accept = 1;
    load(0, RD, 5'd5, 4'd3, 4'd1);
    sample();
    check_val("rd_arb_cycle_cmd", 64'(m_cmd), 64'h0);
    advance();
    sample();
    check_val("rd_m_cmd", 64'(m_cmd), 64'(RD));
    check_val("rd_m_tagid", 64'(m_tagid), 64'(5'b00011));
    check_val("rd_m_addr", 64'(m_addr), 64'd5);
    check_val("rd_u0_accept", 64'(u_cacc[0]), 64'd1);
    advance();
    sample();
    check_val("rd_back_idle", 64'(m_cmd), 64'h0);
    advance();

    // Both masters issue RDs back to back: grants alternate starting with u0
    do_reset();
    s_cmd_accept = 1;
    for (int c = 0; c < 12; c++) begin
      for (int i = 0; i < 2; i++)
        if (cmd[i] == 0) load(i, RD, 5'($urandom), 4'($urandom), 4'd1);
      sample();
      if (m_cmd != 0 && s_cmd_accept) msb_q.push_back(m_tagid[4]);
      advance();
    end
    check_val("alt_count", 64'(msb_q.size()), 64'd6);
    for (int k = 0; k < msb_q.size(); k++)
      check_val($sformatf("alt_msb_%0d", k), 64'(msb_q[k]), 64'(k % 2));
    cmd[0] = 0; cmd[1] = 0;

    // u1 WR burst of 4 while u0 waits with a RD
    do_reset();
    s_cmd_accept = 1; s_data_accept = 1;
    load(1, WR, 5'd9, 4'd6, 4'd4);
    cyc();
    load(0, RD, 5'd2, 4'd1, 4'd1);
    first = -1; beats = 0; last_beat = -1;
    for (int c = 1; c < 10; c++) begin
      sample();
      if (u_cacc[0] && first < 0) first = c;
      if (m_data_valid && s_data_accept) begin
        beats++;
        if (m_data_last) last_beat = beats;
      end
      advance();
    end
    check_val("wr_beats", 64'(beats), 64'd4);
    check_val("wr_last_beat", 64'(last_beat), 64'd4);
    check_val("wr_u0_first_accept", 64'(first), 64'd7);

    // Response routing to u1
    do_reset();
    s_cmd_accept = 0; s_data_accept = 0;
    s_resp = 2'b01; s_tagid = 5'b10010; s_data = 32'hDEADBEEF; s_resp_last = 1;
    racc[0] = 0; racc[1] = 1;
    sample();
    check_val("resp_u1_resp", 64'(u_resp[1]), 64'h1);
    check_val("resp_u1_tagid", 64'(u_rtag[1]), 64'(4'b0010));
    check_val("resp_u1_data", 64'(u_rdata[1]), 64'hDEADBEEF);
    check_val("resp_u0_resp", 64'(u_resp[0]), 64'h0);
    check_val("resp_accept_hi", 64'(m_resp_accept), 64'h1);
    racc[1] = 0;
    #1;
    check_val("resp_accept_lo", 64'(m_resp_accept), 64'h0);
    advance();
    quiet_slave();

    // Reset on the 2nd beat of a WR burst, then a fresh u1 RD
    do_reset();
    s_cmd_accept = 1; s_data_accept = 1;
    load(1, WR, 5'd3, 4'd7, 4'd4);
    cyc(); cyc(); cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    load(1, RD, 5'd4, 4'd2, 4'd1);
    sample();
    all_out = cmd_bus_got() | data_bus_got() | 64'({u_cacc[0], u_cacc[1], u_dacc[0], u_dacc[1],
              m_resp_accept, u_resp[0], u_resp[1], u_rlast[0], u_rlast[1]}) |
              64'(u_rdata[0] | u_rdata[1]) | 64'({u_rtag[0], u_rtag[1]});
    check_val("post_reset_all_zero", all_out, 64'h0);
    advance();
    sample();
    check_val("post_reset_rd_cmd", 64'(m_cmd), 64'(RD));
    check_val("post_reset_rd_msb", 64'(m_tagid[4]), 64'h1);
    advance();

    // Randomized traffic against the model
    do_reset();
    rand_mode = 1;
    g0 = 0; g1 = 0;
    for (int c = 0; c < 4000; c++) begin
      sample();
      if (u_cacc[0] && cmd[0] != 0) g0++;
      if (u_cacc[1] && cmd[1] != 0) g1++;
      advance();
    end
    check_val("fair_both_granted", 64'((g0 > 0) && (g1 > 0)), 64'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
